// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the framebuffer pixel type.
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 521;
  localparam int FB_DEPTH  = H_DISPLAY * V_DISPLAY;
  localparam int PIX_W     = 8;

  typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/vga_fb_addr.sv
// Combinational (v,h) -> linear framebuffer address, v*LINE_W + h built as a
// shift-add over the set bits of the line width (640 = 512 + 128).
module vga_fb_addr
  import vga_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int LINE_W = H_DISPLAY
) (
  input  logic [9:0]        h,
  input  logic [9:0]        v,
  output logic [ADDR_W-1:0] addr
);

  localparam int MB = $clog2(LINE_W + 1);
  localparam logic [MB-1:0] MULT = MB'(LINE_W);

  // part[k] holds h plus the partial product of v with MULT[k-1:0].
  logic [ADDR_W-1:0] part [0:MB];

  assign part[0] = ADDR_W'(h);

  generate
    for (genvar gi = 0; gi < MB; gi++) begin : g_shift_add
      if (MULT[gi]) begin : g_term
        assign part[gi+1] = part[gi] + (ADDR_W'(v) << gi);
      end else begin : g_skip
        assign part[gi+1] = part[gi];
      end
    end
  endgenerate

  assign addr = part[MB];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Time-slot arbiter sharing one single-port framebuffer between VGA fetch and
// a pixel writer. Define VGA_FB_TEARFREE_EN to restrict writes to vertical blanking.
module vga_fb_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter logic [DATA_W-1:0] BLANK_COLOR = '0
) (
  input  logic              clk_50mhz,
  input  logic              clear,
  input  logic              pix_en,
  input  logic [9:0]        h_counter,
  input  logic [9:0]        v_counter,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_oob,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);

  localparam logic [9:0]        H_LIM    = 10'(H_DISPLAY);
  localparam logic [9:0]        V_LIM    = 10'(V_DISPLAY);
  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(H_DISPLAY * V_DISPLAY);

  logic              visible;
  logic              disp_slot;
  logic              wr_window;
  logic              wr_is_oob;
  logic              frame_origin;
  logic [ADDR_W-1:0] rd_addr;

  logic              slot_vld_q, slot_vld_d;
  logic              rd_pending_q, rd_pending_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic              wr_oob_q, wr_oob_d;
  logic              frame_start_q, frame_start_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  vga_fb_addr #(
    .ADDR_W (ADDR_W),
    .LINE_W (H_DISPLAY)
  ) u_addr (
    .h    (h_counter),
    .v    (v_counter),
    .addr (rd_addr)
  );

  assign visible      = (h_counter < H_LIM) && (v_counter < V_LIM);
  assign disp_slot    = pix_en && visible;
  assign wr_is_oob    = (wr_addr >= FB_LIMIT);
  assign frame_origin = pix_en && (h_counter == '0) && (v_counter == '0);

`ifdef VGA_FB_TEARFREE_EN
  assign wr_window = (v_counter >= V_LIM);
`else
  assign wr_window = 1'b1;
`endif

  // Display fetch always wins its slot; writers only ever see free slots.
  always_comb begin
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (!clear) begin
      if (disp_slot) begin
        mem_rd   = 1'b1;
        mem_addr = rd_addr;
      end else if (wr_req && wr_window) begin
        wr_ack    = 1'b1;
        mem_we    = !wr_is_oob;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

  always_comb begin
    slot_vld_d    = pix_en;
    rd_pending_d  = disp_slot;
    pixel_d       = pixel_q;
    wr_oob_d      = wr_oob_q || (wr_ack && wr_is_oob);
    frame_start_d = frame_origin;
    frame_cnt_d   = frame_cnt_q + {7'd0, frame_origin};
    // Read data lands the cycle after the fetch, so stage 2 follows stage 1 directly.
    if (slot_vld_q) begin
      pixel_d = rd_pending_q ? mem_rdata : BLANK_COLOR;
    end
  end

  always_ff @(posedge clk_50mhz or posedge clear) begin
    if (clear) begin
      slot_vld_q    <= 1'b0;
      rd_pending_q  <= 1'b0;
      pixel_q       <= BLANK_COLOR;
      wr_oob_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      slot_vld_q    <= slot_vld_d;
      rd_pending_q  <= rd_pending_d;
      pixel_q       <= pixel_d;
      wr_oob_q      <= wr_oob_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign pixel_out   = pixel_q;
  assign wr_oob      = wr_oob_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: a memory model behind the DUT and a
// pixel scoreboard fed as display slots are driven.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam logic [DW-1:0] BLANK = 8'h00;

  logic          clk_50mhz = 1'b0;
  logic          clear     = 1'b1;
  logic          pix_en    = 1'b0;
  logic [9:0]    h_counter = '0;
  logic [9:0]    v_counter = '0;
  logic          wr_req    = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [DW-1:0] wr_data   = '0;
  logic          wr_ack;
  logic          wr_oob;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] pixel_out;
  logic          frame_start;
  logic [7:0]    frame_cnt;

  logic [DW-1:0] fb     [0:FB_DEPTH-1];
  logic [DW-1:0] ref_fb [0:FB_DEPTH-1];
  logic [DW-1:0] sb_q [$];

  int         n_checks   = 0;
  int         n_errors   = 0;
  logic       pushed_now = 1'b0;
  logic [1:0] hist       = 2'b00;
  logic       oob_sticky = 1'b0;
  logic       prev_fs    = 1'b0;
  logic [7:0] fcnt       = 8'd0;

  vga_fb_arbiter dut (
    .clk_50mhz   (clk_50mhz),
    .clear       (clear),
    .pix_en      (pix_en),
    .h_counter   (h_counter),
    .v_counter   (v_counter),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .wr_oob      (wr_oob),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pixel_out   (pixel_out),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Single-port framebuffer with registered read.
  always @(posedge clk_50mhz) begin
    if (mem_we) fb[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= fb[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic tf_ok(input int v);
    logic tearfree;
`ifdef VGA_FB_TEARFREE_EN
    tearfree = 1'b1;
`else
    tearfree = 1'b0;
`endif
    return !tearfree || (v >= V_DISPLAY);
  endfunction

  // Pixel for a slot driven in cycle T is compared during cycle T+2.
  always @(posedge clk_50mhz) begin
    if (clear) hist <= 2'b00;
    else       hist <= {hist[0], pushed_now};
  end

  always @(negedge clk_50mhz) begin
    if (hist[1] && !clear) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [DW-1:0] exp_px;
        exp_px = sb_q.pop_front();
        $display("pixel: got=%02h exp=%02h", pixel_out, exp_px);
        chk("pixel", 32'(pixel_out), 32'(exp_px));
      end
    end
  end

  task automatic slot(input logic pe, input int h, input int v,
                      input logic req, input int addr, input logic [7:0] data);
    logic vis, disp, ack, oob;
    int   exp_addr;
    @(posedge clk_50mhz); #1;
    pix_en    = pe;
    h_counter = 10'(h);
    v_counter = 10'(v);
    wr_req    = req;
    wr_addr   = AW'(addr);
    wr_data   = data;
    vis  = (h < H_DISPLAY) && (v < V_DISPLAY);
    disp = pe && vis;
    ack  = !disp && req && tf_ok(v);
    oob  = (addr >= FB_DEPTH);
    pushed_now = pe;
    if (pe) sb_q.push_back(vis ? ref_fb[v*H_DISPLAY + h] : BLANK);
    #4;
    if (prev_fs) fcnt++;
    chk("frame_start", 32'(frame_start), 32'(prev_fs));
    chk("frame_cnt", 32'(frame_cnt), 32'(fcnt));
    chk("wr_oob", 32'(wr_oob), 32'(oob_sticky));
    chk("wr_ack", 32'(wr_ack), 32'(ack));
    chk("mem_rd", 32'(mem_rd), 32'(disp));
    chk("mem_we", 32'(mem_we), 32'(ack && !oob));
    exp_addr = disp ? (v*H_DISPLAY + h) : (ack ? addr : 0);
    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (ack && !oob) begin
      chk("mem_wdata", 32'(mem_wdata), 32'(data));
      ref_fb[addr] = data;
    end
    if (ack && oob) oob_sticky = 1'b1;
    prev_fs = pe && (h == 0) && (v == 0);
  endtask

  task automatic do_clear();
    @(posedge clk_50mhz); #1;
    pushed_now = 1'b0;
    clear      = 1'b1;
    pix_en     = 1'b1;
    h_counter  = 10'd5;
    v_counter  = 10'd2;
    wr_req     = 1'b1;
    wr_addr    = AW'(7);
    wr_data    = 8'h11;
    #1;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_pixel", 32'(pixel_out), 32'(BLANK));
    chk("rst_wr_oob", 32'(wr_oob), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(posedge clk_50mhz);
    #1;
    sb_q.delete();
    clear      = 1'b0;
    pix_en     = 1'b0;
    wr_req     = 1'b0;
    oob_sticky = 1'b0;
    prev_fs    = 1'b0;
    fcnt       = 8'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h, v;
    for (int i = 0; i < FB_DEPTH; i++) begin
      fb[i]     = 8'(i*7 + 3);
      ref_fb[i] = 8'(i*7 + 3);
    end
    fb[1285]     = 8'hA5;
    ref_fb[1285] = 8'hA5;

    do_clear();

    // display reads, including the documented (5,2) -> 1285 case
    slot(1, 5, 2, 0, 0, 8'h00);
    slot(0, 5, 2, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      h = $urandom_range(1, H_DISPLAY-1);
      v = $urandom_range(0, V_DISPLAY-1);
      slot(1, h, v, 0, 0, 8'h00);
      slot(0, h, v, 0, 0, 8'h00);
    end

    // active-line write waits for the pix_en=0 slot
    slot(1, 100, 10, 1, 100, 8'h3C);
    slot(0, 100, 10, 1, 100, 8'h3C);
    slot(1, 101, 10, 0, 0, 8'h00);
    slot(0, 101, 10, 0, 0, 8'h00);
    slot(1, 100, 0, 0, 0, 8'h00);
    slot(0, 100, 0, 0, 0, 8'h00);

    // horizontal and vertical blanking, back-to-back writes
    slot(1, 700, 10, 1, 200, 8'h77);
    slot(0, 700, 10, 1, 201, 8'h78);
    slot(1, 701, 10, 1, 202, 8'h79);
    slot(1, 10, 490, 1, 203, 8'h7A);
    slot(0, 10, 490, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      slot(1, 200 + i, 0, 0, 0, 8'h00);
      slot(0, 200 + i, 0, 0, 0, 8'h00);
    end

    // pix_en stuck high across visible pixels starves the writer
    for (int i = 0; i < 4; i++) slot(1, 300 + i, 20, 1, 400, 8'h5E);
    slot(0, 303, 20, 1, 400, 8'h5E);
    slot(0, 303, 20, 0, 0, 8'h00);
    slot(1, 400, 0, 0, 0, 8'h00);
    slot(0, 400, 0, 0, 0, 8'h00);

    // out-of-range and last in-range address
    slot(0, 650, 20, 1, FB_DEPTH, 8'hEE);
    slot(0, 650, 20, 1, FB_DEPTH - 1, 8'hEF);
    for (int i = 0; i < 3; i++) slot(0, 651, 20, 0, 0, 8'h00);
    slot(1, 639, 479, 0, 0, 8'h00);
    slot(0, 639, 479, 0, 0, 8'h00);

    // request in mid-frame, then at start of vertical blanking
    slot(0, 10, 100, 1, 500, 8'h42);
    slot(1, 10, 100, 1, 500, 8'h42);
    slot(0, 11, 100, 1, 500, 8'h42);
    slot(0, 0, 480, 1, 500, 8'h42);
    slot(0, 0, 480, 0, 0, 8'h00);
    slot(1, 500, 0, 0, 0, 8'h00);
    slot(0, 500, 0, 0, 0, 8'h00);

    // clear in the middle of a starved handshake, then re-request
    slot(1, 50, 30, 1, 600, 8'h99);
    do_clear();
    slot(0, 50, 30, 1, 600, 8'h99);
    slot(0, 50, 30, 0, 0, 8'h00);

    // 256 frame starts wrap the frame counter back to 0
    for (int i = 0; i < 256; i++) begin
      slot(1, 0, 0, 0, 0, 8'h00);
      slot(0, 0, 0, 0, 0, 8'h00);
    end
    slot(0, 1, 0, 0, 0, 8'h00);
    chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

    for (int i = 0; i < 3; i++) slot(0, 1, 0, 0, 0, 8'h00);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Time-slot arbiter that shares one single-port framebuffer memory between the VGA display fetch and a pixel writer (draw engine or host). It runs on the 50 MHz system clock alongside the VGA timer, consumes the timer's `h_counter`/`v_counter`, and produces pixel colour aligned one pixel period behind the counters. Writers are serviced in slots the display does not need.

## Interface
- `ADDR_W`, 19: framebuffer address width.
- `DATA_W`, 8: pixel colour width.
- `H_DISPLAY`, 640: visible pixels per line.
- `V_DISPLAY`, 480: visible lines per frame.
- `BLANK_COLOR`, 0: colour output outside the visible area.

Ports:
- `clk_50mhz`  in  1  system clock.
- `clear`  in  1  reset, asynchronous, active-high.
- `pix_en`  in  1  display-slot marker; high on alternate clk_50mhz cycles, once per 25 MHz pixel.
- `h_counter`  in  10  timer horizontal count; stable across each pix_en pair.
- `v_counter`  in  10  timer vertical count.
- `wr_req`  in  1  writer request.
- `wr_addr`  in  ADDR_W  writer linear pixel address.
- `wr_data`  in  DATA_W  writer colour.
- `wr_ack`  out  1  one-cycle pulse when the write is issued.
- `wr_oob`  out  1  sticky: an out-of-range write was acked.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_rd`  out  1  memory read strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  read data, valid the cycle after `mem_rd`.
- `pixel_out`  out  DATA_W  registered pixel colour.
- `frame_start`  out  1  one-cycle pulse at pixel (0,0).
- `frame_cnt`  out  8  frames started since reset, wraps 255→0.

## Operation
- Visible when `h_counter < H_DISPLAY` and `v_counter < V_DISPLAY`.
- Slot classes:
  - Display slot: `pix_en`=1 and visible.
  - Free slot: `pix_en`=0, or `pix_en`=1 and not visible.
- Display slot:
  - `mem_rd`=1; `mem_addr` = `v_counter*H_DISPLAY + h_counter`, computed with shift-add and zero-extended to ADDR_W.
  - Sets `rd_pending`, tagged visible.
- Free slot with `wr_req`=1:
  - `wr_ack`=1, `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`.
- Out-of-range write (`wr_addr` ≥ `H_DISPLAY*V_DISPLAY`):
  - Acked with `mem_we`=0.
  - Sets `wr_oob`; it holds until `clear`.
- `mem_rd` and `mem_we` are never both high. With no grant, both are 0 and `mem_addr` = 0.
- Writer handshake:
  - Writer holds `wr_req`/`wr_addr`/`wr_data` stable until `wr_ack`.
  - Keeping `wr_req` high after ack with new address/data is a back-to-back request.
- Pixel pipeline:
  - Stage 1 registers the slot tag on each `pix_en` cycle.
  - Stage 2, the following cycle: `pixel_out` ← `mem_rdata` if tagged visible, else `BLANK_COLOR`.
- Frame tracking:
  - `frame_start` pulses the cycle after a `pix_en` cycle with h=0,v=0.
  - `frame_cnt` increments on that same cycle.

## Timing
- Reset values:
  - `pixel_out`=`BLANK_COLOR`; `wr_ack`, `wr_oob`, `frame_start`, `frame_cnt`, `rd_pending` = 0.
  - `mem_*` strobes are 0 while `clear` is high.
- `mem_*` outputs are combinational from `pix_en`, counters and `wr_*`. `pixel_out` is registered.
- Latency: `pixel_out` for (h,v) is valid 2 clk_50mhz cycles after its `pix_en` cycle, i.e. one pixel period. Top level delays hsync/vsync/display_on by one pixel.
- Write latency from `wr_req` to `wr_ack`:
  - Active line: ≤1 cycle.
  - Blanking: 0 cycles.
- Boundaries:
  - `pix_en` stuck high during visible area starves the writer and issues no ack.
  - `clear` mid-handshake: no ack; the writer must re-request.
  - Counter wrap 799→0 and 520→0 need no special handling.

## Configuration
- `VGA_FB_TEARFREE_EN` defined:
  - Writes are granted only when `v_counter ≥ V_DISPLAY`; other free slots stay idle.
  - Pending requests wait unacked until vertical blanking.
- Undefined: all free slots serve writes.

## Structure
- Shared package `vga_pkg`: H_DISPLAY/V_DISPLAY/H_TOTAL/V_TOTAL constants, `FB_DEPTH = H_DISPLAY*V_DISPLAY`, pixel colour typedef.
- One sub-module, `vga_fb_addr`: combinational (v,h) → linear address shift-add.

## Test plan
- Reset: assert `clear` during traffic → all outputs at reset values and `mem_rd`=`mem_we`=0 immediately.
- Display read: h=5, v=2, `pix_en`=1 → `mem_addr`=1285, `mem_rd`=1; `mem_rdata`=0xA5 next cycle → `pixel_out`=0xA5 two cycles after the slot.
- Active-line write: h=100, v=10, `wr_req` with addr 100, data 0x3C → `wr_ack` and `mem_we` in the next `pix_en`=0 cycle, `mem_addr`=100, `mem_wdata`=0x3C.
- Blanking: h=700, `pix_en`=1, `wr_req` → immediate ack and `mem_we`; `pixel_out`=`BLANK_COLOR` two cycles later; back-to-back requests are acked every cycle.
- Out-of-range write: `wr_addr`=307200 → ack with `mem_we`=0; `wr_oob`=1 persists until `clear`.
- With `VGA_FB_TEARFREE_EN`: request at v=100 → no ack until the first free slot at v=480; `frame_cnt` 255→0 on the next frame start.
